// File: rtl/vending_lcd_text_builder.sv
// Builds the two 16-character LCD lines and the cursor address for the vending machine.
// Line 1 shows the balance, converted to decimal by double-dabble; line 2 shows the idle prompt or a timed event message.
module vending_lcd_text_builder #(
    parameter int unsigned MSG_TICKS = 200
) (
    input  logic         clk_100hz,
    input  logic         rst,
    input  logic [13:0]  balance_i,
    input  logic         upd_i,
    input  logic         ev_valid_i,
    input  logic [2:0]   ev_code_i,
    output logic [127:0] line1_text_o,
    output logic [127:0] line2_text_o,
    output logic [6:0]   ddram_address_o,
    output logic         busy_o,
    output logic         msg_active_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StConv = 2'd1;
    localparam logic [1:0] StFmt  = 2'd2;

    localparam logic [13:0]  MaxShown   = 14'd9999;
    localparam logic [3:0]   LastShift  = 4'd13;
    localparam logic [15:0]  MsgLast    = 16'(MSG_TICKS - 1);
    localparam logic [6:0]   AddrIdle   = 7'h0E;
    localparam logic [6:0]   AddrMsg    = 7'h40;
    localparam logic [7:0]   AsciiSpace = 8'h20;
    localparam logic [7:0]   AsciiZero  = 8'h30;
    localparam logic [7:0]   AsciiW     = 8'h57;

    localparam logic [87:0]  Line1Prefix = "BALANCE    ";
    localparam logic [127:0] Line1Reset  = "BALANCE       0W";
    localparam logic [127:0] TxtIdle     = "SELECT ITEM     ";
    localparam logic [127:0] TxtSoldOut  = "SOLD OUT        ";
    localparam logic [127:0] TxtNoMoney  = "NOT ENOUGH MONEY";
    localparam logic [127:0] TxtTakeItem = "TAKE YOUR ITEM  ";
    localparam logic [127:0] TxtChange   = "CHANGE RETURNED ";

    logic [1:0]   state_q, state_d;
    logic [13:0]  bin_q, bin_d;
    logic [15:0]  bcd_q, bcd_d;
    logic [3:0]   shift_cnt_q, shift_cnt_d;
    logic         busy_q, busy_d;
    logic         pending_q, pending_d;
    logic [127:0] line1_q, line1_d;
    logic [127:0] line2_q, line2_d;
    logic         msg_active_q, msg_active_d;
    logic [15:0]  msg_cnt_q, msg_cnt_d;
    logic [6:0]   ddram_q, ddram_d;

    logic [14:0]  bcd_adj;
    logic [13:0]  balance_clamped;
    logic [127:0] line1_fmt;
    logic         ev_legal;

    function automatic logic [7:0] to_ascii(input logic [3:0] digit);
        return AsciiZero + {4'h0, digit};
    endfunction

    function automatic logic [127:0] msg_text(input logic [2:0] code);
        logic [127:0] txt;
        case (code)
            3'd1:    txt = TxtSoldOut;
            3'd2:    txt = TxtNoMoney;
            3'd3:    txt = TxtTakeItem;
            default: txt = TxtChange;
        endcase
        return txt;
    endfunction

    assign balance_clamped = (balance_i > MaxShown) ? MaxShown : balance_i;
    assign ev_legal = ev_valid_i && (ev_code_i >= 3'd1) && (ev_code_i <= 3'd4);

    // Bit 15 of the adjusted value is shifted out, so the top nibble keeps only its low 3 bits.
    always_comb begin
        bcd_adj = bcd_q[14:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (bcd_q[15:12] >= 4'd5) begin
            bcd_adj[14:12] = bcd_q[14:12] + 3'd3;
        end
    end

    // Leading zeros become spaces; the units digit is always shown.
    always_comb begin
        logic show3, show2, show1;
        show3 = (bcd_q[15:12] != 4'd0);
        show2 = show3 || (bcd_q[11:8] != 4'd0);
        show1 = show2 || (bcd_q[7:4] != 4'd0);
        line1_fmt = {Line1Prefix,
                     show3 ? to_ascii(bcd_q[15:12]) : AsciiSpace,
                     show2 ? to_ascii(bcd_q[11:8])  : AsciiSpace,
                     show1 ? to_ascii(bcd_q[7:4])   : AsciiSpace,
                     to_ascii(bcd_q[3:0]),
                     AsciiW};
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        busy_d      = busy_q;
        pending_d   = pending_q;
        line1_d     = line1_q;
        case (state_q)
            StIdle: begin
                if (upd_i || pending_q) begin
                    state_d     = StConv;
                    bin_d       = balance_clamped;
                    bcd_d       = 16'h0000;
                    shift_cnt_d = 4'd0;
                    busy_d      = 1'b1;
                    pending_d   = 1'b0;
                end
            end
            StConv: begin
                pending_d      = pending_q || upd_i;
                {bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
                shift_cnt_d    = shift_cnt_q + 4'd1;
                if (shift_cnt_q == LastShift) begin
                    state_d = StFmt;
                end
            end
            StFmt: begin
                pending_d = pending_q || upd_i;
                line1_d   = line1_fmt;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // A legal event always wins, including one that coincides with expiry.
    always_comb begin
        line2_d      = line2_q;
        msg_active_d = msg_active_q;
        msg_cnt_d    = msg_cnt_q;
        ddram_d      = ddram_q;
        if (ev_legal) begin
            line2_d      = msg_text(ev_code_i);
            msg_active_d = 1'b1;
            msg_cnt_d    = 16'd0;
            ddram_d      = AddrMsg;
        end else if (msg_active_q) begin
            if (msg_cnt_q == MsgLast) begin
                line2_d      = TxtIdle;
                msg_active_d = 1'b0;
                msg_cnt_d    = 16'd0;
                ddram_d      = AddrIdle;
            end else begin
                msg_cnt_d = msg_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            bin_q        <= 14'd0;
            bcd_q        <= 16'h0000;
            shift_cnt_q  <= 4'd0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            line1_q      <= Line1Reset;
            line2_q      <= TxtIdle;
            msg_active_q <= 1'b0;
            msg_cnt_q    <= 16'd0;
            ddram_q      <= AddrIdle;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            shift_cnt_q  <= shift_cnt_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            line1_q      <= line1_d;
            line2_q      <= line2_d;
            msg_active_q <= msg_active_d;
            msg_cnt_q    <= msg_cnt_d;
            ddram_q      <= ddram_d;
        end
    end

    assign line1_text_o    = line1_q;
    assign line2_text_o    = line2_q;
    assign ddram_address_o = ddram_q;
    assign busy_o          = busy_q;
    assign msg_active_o    = msg_active_q;

endmodule

// File: tb/tb_vending_lcd_text_builder.sv
// Scoreboard bench for vending_lcd_text_builder: stimulus pushes expected line updates,
// and a negedge monitor pops and compares them whenever the DUT outputs change.
module tb_vending_lcd_text_builder;

    typedef struct {
        logic [127:0] text;
        logic [6:0]   addr;
        logic         act;
        int           at;
    } exp_t;

    logic         clk_100hz;
    logic         rst;
    logic [13:0]  balance_i;
    logic         upd_i;
    logic         ev_valid_i;
    logic [2:0]   ev_code_i;
    logic [127:0] line1_text_o;
    logic [127:0] line2_text_o;
    logic [6:0]   ddram_address_o;
    logic         busy_o;
    logic         msg_active_o;

    exp_t l1_q[$];
    exp_t l2_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    localparam logic [127:0] TxtIdle   = "SELECT ITEM     ";
    localparam logic [127:0] TxtSold   = "SOLD OUT        ";
    localparam logic [127:0] TxtMoney  = "NOT ENOUGH MONEY";
    localparam logic [127:0] TxtTake   = "TAKE YOUR ITEM  ";
    localparam logic [127:0] TxtChange = "CHANGE RETURNED ";
    localparam logic [127:0] TxtBal0   = "BALANCE       0W";

    vending_lcd_text_builder #(.MSG_TICKS(200)) dut (
        .clk_100hz       (clk_100hz),
        .rst             (rst),
        .balance_i       (balance_i),
        .upd_i           (upd_i),
        .ev_valid_i      (ev_valid_i),
        .ev_code_i       (ev_code_i),
        .line1_text_o    (line1_text_o),
        .line2_text_o    (line2_text_o),
        .ddram_address_o (ddram_address_o),
        .busy_o          (busy_o),
        .msg_active_o    (msg_active_o)
    );

    initial clk_100hz = 1'b0;
    always #5 clk_100hz = ~clk_100hz;
    always @(posedge clk_100hz) edge_n <= edge_n + 1;

    task automatic chk_txt(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_l1(input logic [127:0] text, input int at);
        exp_t e;
        e.text = text; e.addr = 7'h0; e.act = 1'b0; e.at = at;
        l1_q.push_back(e);
    endtask

    task automatic push_l2(input logic [127:0] text, input logic [6:0] addr, input logic act,
                           input int at);
        exp_t e;
        e.text = text; e.addr = addr; e.act = act; e.at = at;
        l2_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (edge_n < t) begin
            @(posedge clk_100hz);
            #1;
        end
    endtask

    task automatic do_upd(input logic [13:0] bal, output int k);
        @(negedge clk_100hz);
        balance_i = bal;
        upd_i     = 1'b1;
        @(posedge clk_100hz);
        #1;
        k     = edge_n;
        upd_i = 1'b0;
    endtask

    task automatic pulse_ev(input logic [2:0] code, output int k);
        @(negedge clk_100hz);
        ev_valid_i = 1'b1;
        ev_code_i  = code;
        @(posedge clk_100hz);
        #1;
        k          = edge_n;
        ev_valid_i = 1'b0;
        ev_code_i  = 3'd0;
    endtask

    task automatic do_both(input logic [13:0] bal, input logic [2:0] code, output int k);
        @(negedge clk_100hz);
        balance_i  = bal;
        upd_i      = 1'b1;
        ev_valid_i = 1'b1;
        ev_code_i  = code;
        @(posedge clk_100hz);
        #1;
        k          = edge_n;
        upd_i      = 1'b0;
        ev_valid_i = 1'b0;
        ev_code_i  = 3'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 64) begin
            @(posedge clk_100hz);
            #1;
            n++;
        end
        if (busy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy timeout: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_txt({tag, " line1"}, line1_text_o, TxtBal0);
        chk_txt({tag, " line2"}, line2_text_o, TxtIdle);
        chk_val({tag, " ddram"}, 32'(ddram_address_o), 32'h0E);
        chk_val({tag, " busy"}, 32'(busy_o), 32'd0);
        chk_val({tag, " msg_active"}, 32'(msg_active_o), 32'd0);
    endtask

    // Monitor: any output change pops one expectation from the matching queue.
    initial begin
        logic [127:0] l1_prev, l2_prev;
        logic [6:0]   addr_prev;
        logic         busy_prev, act_prev;
        exp_t         e;
        l1_prev = '0; l2_prev = '0; addr_prev = '0; busy_prev = 1'b0; act_prev = 1'b0;
        forever begin
            @(negedge clk_100hz);
            if (rst === 1'b1) begin
                if ((busy_prev && !busy_o) || (line1_text_o !== l1_prev)) begin
                    if (l1_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL line1 unexpected: got \"%s\" busy %0b at edge %0d, expected no update",
                                 line1_text_o, busy_o, edge_n);
                    end else begin
                        e = l1_q.pop_front();
                        chk_txt("line1 text", line1_text_o, e.text);
                        chk_val("line1 edge", 32'(edge_n), 32'(e.at));
                    end
                end
                if ((line2_text_o !== l2_prev) || (msg_active_o !== act_prev) ||
                    (ddram_address_o !== addr_prev)) begin
                    if (l2_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL line2 unexpected: got \"%s\" at edge %0d, expected no change",
                                 line2_text_o, edge_n);
                    end else begin
                        e = l2_q.pop_front();
                        chk_txt("line2 text", line2_text_o, e.text);
                        chk_val("line2 ddram", 32'(ddram_address_o), 32'(e.addr));
                        chk_val("line2 msg_active", 32'(msg_active_o), 32'(e.act));
                        chk_val("line2 edge", 32'(edge_n), 32'(e.at));
                    end
                end
            end
            l1_prev   = line1_text_o;
            l2_prev   = line2_text_o;
            addr_prev = ddram_address_o;
            busy_prev = busy_o;
            act_prev  = msg_active_o;
        end
    end

    initial begin
        logic [13:0]  bals [8];
        logic [127:0] txts [8];
        int k, k2, k3, n;

        bals = '{14'd12000, 14'd7, 14'd10, 14'd305, 14'd9999, 14'd1000, 14'd16383, 14'd0};
        txts = '{"BALANCE    9999W", "BALANCE       7W", "BALANCE      10W",
                 "BALANCE     305W", "BALANCE    9999W", "BALANCE    1000W",
                 "BALANCE    9999W", "BALANCE       0W"};

        rst = 1'b0; balance_i = 14'd0; upd_i = 1'b0; ev_valid_i = 1'b0; ev_code_i = 3'd0;
        repeat (3) @(negedge clk_100hz);
        rst = 1'b1;
        @(negedge clk_100hz);
        chk_reset_outputs("reset");

        // 1500: busy across edges k..k+14, line1 untouched until edge k+15.
        do_upd(14'd1500, k);
        push_l1("BALANCE    1500W", k + 15);
        for (int i = 0; i < 15; i++) begin
            chk_val("busy during conversion", 32'(busy_o), 32'd1);
            if (i == 14) chk_txt("line1 held during conversion", line1_text_o, TxtBal0);
            @(posedge clk_100hz);
            #1;
        end
        chk_val("busy after fmt", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk_100hz);

        for (int i = 0; i < 8; i++) begin
            do_upd(bals[i], k);
            push_l1(txts[i], k + 15);
            wait_idle();
            repeat (2) @(posedge clk_100hz);
        end

        // Two upd pulses during a conversion collapse into a single re-conversion.
        do_upd(14'd500, k);
        push_l1("BALANCE     500W", k + 15);
        push_l1("BALANCE     800W", k + 31);
        do_upd(14'd800, k2);
        do_upd(14'd800, k2);
        wait_until(k + 31 + 40);

        // Plain message for the full 200 ticks; an illegal code while idle does nothing.
        pulse_ev(3'd7, k);
        pulse_ev(3'd2, k);
        push_l2(TxtMoney, 7'h40, 1'b1, k);
        push_l2(TxtIdle, 7'h0E, 1'b0, k + 200);
        wait_until(k + 210);

        // Replacement at cycle 150; illegal codes in between must not disturb the count.
        pulse_ev(3'd2, k);
        push_l2(TxtMoney, 7'h40, 1'b1, k);
        wait_until(k + 49);
        pulse_ev(3'd6, k2);
        pulse_ev(3'd0, k2);
        wait_until(k + 149);
        pulse_ev(3'd3, k2);
        push_l2(TxtTake, 7'h40, 1'b1, k2);
        push_l2(TxtIdle, 7'h0E, 1'b0, k2 + 200);
        wait_until(k2 + 210);

        // New event landing on the expiry edge wins.
        pulse_ev(3'd2, k);
        push_l2(TxtMoney, 7'h40, 1'b1, k);
        wait_until(k + 199);
        pulse_ev(3'd4, k2);
        push_l2(TxtChange, 7'h40, 1'b1, k2);
        push_l2(TxtIdle, 7'h0E, 1'b0, k2 + 200);
        wait_until(k2 + 210);

        // Simultaneous upd and event are both serviced.
        do_both(14'd321, 3'd1, k);
        push_l1("BALANCE     321W", k + 15);
        push_l2(TxtSold, 7'h40, 1'b1, k);
        push_l2(TxtIdle, 7'h0E, 1'b0, k + 200);
        wait_until(k + 210);

        // Reset mid-conversion (with a pending request) and mid-message.
        do_both(14'd1234, 3'd1, k3);
        push_l2(TxtSold, 7'h40, 1'b1, k3);
        do_upd(14'd555, k);
        repeat (2) @(posedge clk_100hz);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        repeat (2) @(negedge clk_100hz);
        rst = 1'b1;
        repeat (20) @(posedge clk_100hz);
        #1;
        chk_reset_outputs("after reset");
        do_upd(14'd42, k);
        push_l1("BALANCE      42W", k + 15);
        wait_idle();

        n = 0;
        while ((l1_q.size() != 0 || l2_q.size() != 0) && n < 300) begin
            @(posedge clk_100hz);
            n++;
        end
        repeat (3) @(posedge clk_100hz);
        chk_val("line1 queue drained", 32'(l1_q.size()), 32'd0);
        chk_val("line2 queue drained", 32'(l2_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
